// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 multiplier controller. Time-shares one external 4x4
// sub-multiplier across the four quadrant partial products, combining
// them either by exact shift-add (MODE 0) or by OR compression (MODE 1).
module mult_8x8_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic        MODE,
  output logic [3:0]  SUB_A,
  output logic [3:0]  SUB_B,
  output logic [1:0]  SUB_SEL,
  input  logic [7:0]  SUB_R,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] R
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        mode_q, mode_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] r_q, r_d;
  logic        out_valid_q, out_valid_d;

  logic        accept;
  logic        in_pass;
  logic [3:0]  shamt;
  logic [15:0] pp;
  logic [15:0] acc_nxt;

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state: four passes after accept, then hold in DONE until drained
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (IN_VALID) state_d = ST_P0;
      ST_P0:   state_d = ST_P1;
      ST_P1:   state_d = ST_P2;
      ST_P2:   state_d = ST_P3;
      ST_P3:   state_d = ST_DONE;
      ST_DONE: if (OUT_READY) state_d = IN_VALID ? ST_P0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and sub-multiplier drive; operand nibbles come only from latched copies
  always_comb begin
    IN_READY = (state_q == ST_IDLE) || ((state_q == ST_DONE) && OUT_READY);
    SUB_A    = 4'd0;
    SUB_B    = 4'd0;
    SUB_SEL  = 2'd0;
    shamt    = 4'd0;
    in_pass  = 1'b1;
    case (state_q)
      ST_P0: begin SUB_A = a_q[3:0]; SUB_B = b_q[3:0]; SUB_SEL = 2'd0; shamt = 4'd0; end
      ST_P1: begin SUB_A = a_q[3:0]; SUB_B = b_q[7:4]; SUB_SEL = 2'd1; shamt = 4'd4; end
      ST_P2: begin SUB_A = a_q[7:4]; SUB_B = b_q[3:0]; SUB_SEL = 2'd2; shamt = 4'd4; end
      ST_P3: begin SUB_A = a_q[7:4]; SUB_B = b_q[7:4]; SUB_SEL = 2'd3; shamt = 4'd8; end
      default: in_pass = 1'b0;
    endcase
    OUT_VALID = out_valid_q;
    R         = r_q;
  end

  // Accumulate the weighted partial product; add wraps mod 2^16
  always_comb begin
    accept  = IN_READY && IN_VALID;
    pp      = {8'h00, SUB_R} << shamt;
    acc_nxt = mode_q ? (acc_q | pp) : (acc_q + pp);

    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;

    if (in_pass) acc_d = acc_nxt;
    if (state_q == ST_P3) begin
      r_d         = acc_nxt;
      out_valid_d = 1'b1;
    end
    if ((state_q == ST_DONE) && OUT_READY) out_valid_d = 1'b0;
    if (accept) begin
      a_d    = A;
      b_d    = B;
      mode_d = MODE;
      acc_d  = '0;
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Directed bench for mult_8x8_seq_ctrl with an exact 4x4 model or a
// constant 0xFF stub standing in for the shared sub-multiplier.
module tb_mult_8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [7:0]  a, b;
  logic        mode;
  logic [3:0]  sub_a, sub_b;
  logic [1:0]  sub_sel;
  logic [7:0]  sub_r;
  logic        out_valid, out_ready;
  logic [15:0] r;
  logic        stub;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign sub_r = stub ? 8'hFF : ({4'h0, sub_a} * {4'h0, sub_b});

  mult_8x8_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .MODE(mode),
    .SUB_A(sub_a), .SUB_B(sub_b), .SUB_SEL(sub_sel), .SUB_R(sub_r),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .R(r)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outs(input string nm);
    nvec++;
    if ({in_ready, out_valid, r, sub_a, sub_b, sub_sel} !== {1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 2'h0}) begin
      nerr++;
      $display("FAIL %s got rdy=%b vld=%b r=%h sa=%h sb=%h sel=%0d exp rdy=1 vld=0 r=0000 sub=0",
               nm, in_ready, out_valid, r, sub_a, sub_b, sub_sel);
    end
  endtask

  // Accept a pair (from IDLE), walk four passes, leave the FSM in DONE.
  // chk_nib checks the nibble pairs against the operands.
  task automatic run_op(input string nm, input logic [7:0] ia, input logic [7:0] ib,
                        input logic im, input logic [15:0] exp_r, input bit chk_nib,
                        input bit perturb);
    logic [3:0] ea, eb;
    in_valid = 1'b1; a = ia; b = ib; mode = im;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL %s_inready got %b exp 1", nm, in_ready);
    end
    step();
    in_valid = 1'b0;
    if (perturb) begin a = ~ia; b = ~ib; mode = ~im; end
    for (int p = 0; p < 4; p++) begin
      ea = (p >= 2) ? ia[7:4] : ia[3:0];
      eb = (p[0])   ? ib[7:4] : ib[3:0];
      nvec++;
      if (sub_sel !== p[1:0] || out_valid !== 1'b0 ||
          (chk_nib && (sub_a !== ea || sub_b !== eb))) begin
        nerr++;
        $display("FAIL %s_pass%0d got sel=%0d a=%h b=%h vld=%b exp sel=%0d a=%h b=%h vld=0",
                 nm, p, sub_sel, sub_a, sub_b, out_valid, p, ea, eb);
      end
      step();
    end
    nvec++;
    if (out_valid !== 1'b1 || r !== exp_r) begin
      nerr++; $display("FAIL %s_result got vld=%b r=%h exp vld=1 r=%h", nm, out_valid, r, exp_r);
    end
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL %s_drain got vld=%b rdy=%b exp vld=0 rdy=1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b0; stub = 1'b0;
    #12;
    check_idle_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_idle_outs("post_reset_idle");
  endtask

  task automatic test_exact();
    run_op("exact_12x34", 8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1, 1'b0);
    drain("exact_12x34");
    run_op("exact_FFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1, 1'b0);
    drain("exact_FFxFF");
  endtask

  task automatic test_or_combine();
    run_op("or_12x34", 8'h12, 8'h34, 1'b1, 16'h0368, 1'b1, 1'b0);
    drain("or_12x34");
    run_op("or_perturb", 8'h12, 8'h34, 1'b1, 16'h0368, 1'b1, 1'b1);
    drain("or_perturb");
  endtask

  task automatic test_wrap();
    stub = 1'b1;
    run_op("wrap_add", 8'h5A, 8'hC3, 1'b0, 16'h1FDF, 1'b0, 1'b0);
    drain("wrap_add");
    run_op("wrap_or", 8'h5A, 8'hC3, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    drain("wrap_or");
    stub = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_op("bp", 8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if (out_valid !== 1'b1 || r !== 16'h03A8 || in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold%0d got vld=%b r=%h rdy=%b exp vld=1 r=03a8 rdy=0", i, out_valid, r, in_ready);
      end
    end
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h03; b = 8'h05; mode = 1'b0;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL b2b_inready got %b exp 1", in_ready);
    end
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      nvec++;
      if (out_valid !== 1'b0 || sub_sel !== p[1:0]) begin
        nerr++; $display("FAIL b2b_pass%0d got vld=%b sel=%0d exp vld=0 sel=%0d", p, out_valid, sub_sel, p);
      end
      step();
    end
    nvec++;
    if (out_valid !== 1'b1 || r !== 16'h000F) begin
      nerr++; $display("FAIL b2b_result got vld=%b r=%h exp vld=1 r=000f", out_valid, r);
    end
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; a = 8'hAB; b = 8'hCD; mode = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step();
    nvec++;
    if (sub_sel !== 2'd2) begin
      nerr++; $display("FAIL mid_in_p2 got sel=%0d exp 2", sub_sel);
    end
    rst_n = 1'b0;
    #1;
    check_idle_outs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_op("after_reset", 8'h10, 8'h10, 1'b0, 16'h0100, 1'b1, 1'b0);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_exact();
    test_or_combine();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Watchdog: fixed-latency flow, so any overrun is a failure
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_8x8_seq_ctrl.md
# mult_8x8_seq_ctrl

Sequential 8x8 multiplier controller that time-shares a single external 4x4 approximate sub-multiplier across the four quadrant partial products of an 8x8 product. It accepts operands over a valid/ready handshake, drives the shared 4x4 unit for four passes, and combines the partial products into a 16-bit result. Combination is either exact shift-add or the OR-compressor style used by the combinational 8x8 approximate multipliers. It sits between an operand source and a result sink wherever area matters more than throughput.

## Interface
- Parameters: none; widths fixed at 8x8 -> 16.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- IN_VALID  in  1  operand pair valid
- IN_READY  out  1  controller can accept operands
- A  in  8  multiplicand
- B  in  8  multiplier
- MODE  in  1  combine mode, sampled at accept: 0 = shift-add, 1 = OR combine
- SUB_A  out  4  operand A nibble to shared 4x4 unit
- SUB_B  out  4  operand B nibble to shared 4x4 unit
- SUB_SEL  out  2  quadrant index / variant select for shared unit (0=LL, 1=LH, 2=HL, 3=HH)
- SUB_R  in  8  4x4 product from shared unit, combinational, same cycle
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  sink accepts result
- R  out  16  product

## Operation
- States: IDLE, P0, P1, P2, P3, DONE.
- IDLE: IN_READY=1. When IN_VALID=1, latch A, B and MODE, clear the accumulator, and go to P0.
- Passes, one per cycle. In each pass, SUB_A/SUB_B/SUB_SEL are driven from registered operands and SUB_R is captured at the end of the cycle:
  - P0: A[3:0], B[3:0], SEL 0, weight <<0
  - P1: A[3:0], B[7:4], SEL 1, weight <<4
  - P2: A[7:4], B[3:0], SEL 2, weight <<4
  - P3: A[7:4], B[7:4], SEL 3, weight <<8
- MODE 0: acc <= acc + (zero-extended SUB_R << weight), 16-bit, wraps modulo 2^16. The carry out of bit 15 is discarded.
- MODE 1: acc <= acc | (zero-extended SUB_R << weight).
- P3 goes to DONE. R updates with the final accumulator value on that transition.
- DONE: OUT_VALID=1 and R is held stable until OUT_READY=1.
  - OUT_READY=1 with IN_VALID=0: go to IDLE.
  - OUT_READY=1 with IN_VALID=1: new operands are accepted in the same cycle (IN_READY = OUT_READY while in DONE) and the FSM goes directly to P0.
- In IDLE, DONE and reset, SUB_A, SUB_B and SUB_SEL drive 0.
- A, B and MODE changes after accept have no effect on the operation in flight.

## Timing
- Reset, asynchronous and immediate from any state including mid-pass:
  - state=IDLE, IN_READY=1, OUT_VALID=0, R=0, SUB_A=SUB_B=SUB_SEL=0, accumulator=0.
  - The in-flight operation is discarded.
  - After rst_n deasserts, the first accept happens at the first rising edge with IN_VALID=1.
- Latency: operands accepted at edge t; passes occupy cycles t..t+3; OUT_VALID=1 from edge t+4.
- Throughput: one result per 5 cycles with back-to-back accept in DONE.
- IN_READY is combinational from state and OUT_READY only; no combinational path from IN_VALID. OUT_VALID and R are registered.
- OUT_VALID never drops without a handshake. R never changes while OUT_VALID=1 and OUT_READY=0.

## Test plan
- Bench uses an exact 4x4 model for SUB_R unless stated otherwise.
- Reset: hold rst_n=0 -> IN_READY=1, OUT_VALID=0, R=0x0000, SUB_* = 0.
- Exact, MODE 0, A=0x12, B=0x34 -> SUB_SEL sequence 0,1,2,3 with nibble pairs (2,4),(2,3),(1,4),(1,3); R=0x03A8, OUT_VALID 4 edges after accept. Then A=0xFF, B=0xFF -> R=0xFE01.
- OR combine, MODE 1, A=0x12, B=0x34 -> R=0x0368. Also verify that changing MODE after accept does not alter the result.
- Wrap: stub SUB_R=0xFF constant, MODE 0 -> R=0x1FDF, truncated from 0x11FDF. Same stub with MODE 1 -> R=0xFFFF.
- Backpressure and back-to-back:
  - Hold OUT_READY=0 for 3 cycles in DONE -> R stable, IN_READY=0.
  - Then OUT_READY=1 with IN_VALID=1, A=0x03, B=0x05 -> that edge completes the handshake and accepts the new pair; the next result, R=0x000F, is valid 4 edges later.
- Reset mid-operation: assert rst_n=0 during P2 -> outputs return immediately to reset values. The next transaction after deassertion, A=0x10, B=0x10, MODE 0 -> R=0x0100.
